// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared display-select encodings, view FSM states and address limits
package disp_pkg;

    localparam logic [1:0] DISP_REG   = 2'b00;
    localparam logic [1:0] DISP_MEM   = 2'b01;
    localparam logic [1:0] DISP_INSTR = 2'b10;

    localparam int DISP_REG_LAST = 31;
    localparam int DISP_MEM_LAST = 127;

    // State codes equal the Ctl encodings so the state register drives Ctl directly
    typedef enum logic [1:0] {
        S_REG   = DISP_REG,
        S_MEM   = DISP_MEM,
        S_INSTR = DISP_INSTR
    } disp_state_t;

    function automatic disp_state_t next_view(input disp_state_t cur);
        case (cur)
            S_REG:   next_view = S_MEM;
            S_MEM:   next_view = S_INSTR;
            default: next_view = S_REG;
        endcase
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// rtl/disp_scan_ctrl_if.sv - front-panel buttons/switch in, display select and debug address out
interface disp_scan_ctrl_if;
    logic       BtnMode;
    logic       BtnNext;
    logic       BtnPrev;
    logic       Freeze;
    logic [1:0] Ctl;
    logic [6:0] Addr;
    logic       Step;

    modport master (output BtnMode, BtnNext, BtnPrev, Freeze, input Ctl, Addr, Step);
    modport slave  (input BtnMode, BtnNext, BtnPrev, Freeze, output Ctl, Addr, Step);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability debounce and rising-edge press pulse
module btn_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1, sync2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Count only while the input disagrees with the accepted level; any bounce back restarts it
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - view-mode FSM and debug address stepping; DISP_SCAN_AUTOSCAN_EN adds timed auto-step
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCAN_CYCLES     = 50000000,
    parameter int REG_LAST        = DISP_REG_LAST,
    parameter int MEM_LAST        = DISP_MEM_LAST
) (
    input  logic                   CLK,
    input  logic                   Reset,
    disp_scan_ctrl_if.slave        bus
);
    localparam logic [6:0] REG_MAX = 7'(REG_LAST);
    localparam logic [6:0] MEM_MAX = 7'(MEM_LAST);

    disp_state_t state, state_n;
    logic [6:0]  addr, addr_n, last;
    logic        step, step_n;
    logic        mode_p, next_p, prev_p, any_press, auto_p;

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (.clk(CLK), .rst_n(Reset), .raw(bus.BtnMode), .press(mode_p));
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (.clk(CLK), .rst_n(Reset), .raw(bus.BtnNext), .press(next_p));
    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (.clk(CLK), .rst_n(Reset), .raw(bus.BtnPrev), .press(prev_p));

    assign any_press = mode_p | next_p | prev_p;

`ifdef DISP_SCAN_AUTOSCAN_EN
    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic [SW-1:0] scan_cnt;
    logic          scan_run;

    assign scan_run = !bus.Freeze && (state != S_INSTR);
    // A manual press in the wrap cycle suppresses the auto step and restarts the period
    assign auto_p   = scan_run && !any_press && (scan_cnt == SW'(SCAN_CYCLES - 1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            scan_cnt <= '0;
        end else if (any_press || !scan_run || scan_cnt == SW'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
`else
    localparam int unused_scan_cycles = SCAN_CYCLES;
    logic unused_freeze;
    assign unused_freeze = bus.Freeze;
    assign auto_p        = 1'b0;
`endif

    assign last = (state == S_REG) ? REG_MAX : MEM_MAX;

    always_comb begin
        state_n = state;
        addr_n  = addr;
        step_n  = 1'b0;
        if (mode_p) begin
            state_n = next_view(state);
            addr_n  = '0;
            step_n  = 1'b1;
        end else if (state != S_INSTR) begin
            if (prev_p && !next_p) begin
                addr_n = (addr == '0) ? last : addr - 1'b1;
                step_n = 1'b1;
            end else if ((next_p && !prev_p) || auto_p) begin
                addr_n = (addr == last) ? '0 : addr + 1'b1;
                step_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_REG;
            addr  <= '0;
            step  <= 1'b0;
        end else begin
            state <= state_n;
            addr  <= addr_n;
            step  <= step_n;
        end
    end

    assign bus.Ctl  = state;
    assign bus.Addr = addr;
    assign bus.Step = step;
endmodule
